// File: rtl/fft_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : fft_seq_ctrl_if
//  Brief   : Load, compute-address and unload signal bundle of the FFT
//            sequencer. The master side is the controller; the slave side is
//            the datapath/host environment.
//  Revision: 1.0 - initial release
// ============================================================================
interface fft_seq_ctrl_if #(
  parameter int ADDRSIZE = 5
);
  // load stream
  logic                ld_valid;
  logic                ld_ready;
  logic                ld_we;
  logic [ADDRSIZE-1:0] ld_addr;
  // compute control
  logic                start;
  logic                inverse;
  logic                rd_en;
  logic [ADDRSIZE-1:0] rd_addr_a;
  logic [ADDRSIZE-1:0] rd_addr_b;
  logic [ADDRSIZE-2:0] tw_idx;
  logic                tw_conj;
  logic                wr_en;
  logic [ADDRSIZE-1:0] wr_addr_a;
  logic [ADDRSIZE-1:0] wr_addr_b;
  logic [ADDRSIZE-1:0] stage_num;
  logic                busy;
  // unload stream
  logic                ul_valid;
  logic                ul_ready;
  logic [ADDRSIZE-1:0] ul_addr;
  logic                ul_last;
  logic                done;

  modport master (
    input  ld_valid, start, inverse, ul_ready,
    output ld_ready, ld_we, ld_addr,
    output rd_en, rd_addr_a, rd_addr_b, tw_idx, tw_conj,
    output wr_en, wr_addr_a, wr_addr_b, stage_num, busy,
    output ul_valid, ul_addr, ul_last, done
  );

  modport slave (
    output ld_valid, start, inverse, ul_ready,
    input  ld_ready, ld_we, ld_addr,
    input  rd_en, rd_addr_a, rd_addr_b, tw_idx, tw_conj,
    input  wr_en, wr_addr_a, wr_addr_b, stage_num, busy,
    input  ul_valid, ul_addr, ul_last, done
  );
endinterface
`default_nettype wire

// File: rtl/fft_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : fft_seq_ctrl
//  Brief   : Sequencer for an in-place radix-2 DIF FFT. Loads N samples in
//            natural order, issues one butterfly per cycle for log2(N)
//            stages with write-back delayed by the PE latency, then unloads
//            in natural order using bit-reversed read addresses.
//  Revision: 1.0 - initial release
// ============================================================================
module fft_seq_ctrl #(
  parameter int NUMSAMPLES = 32,
  parameter int ADDRSIZE   = 5,
  parameter int NUMSTAGES  = 5,
  parameter int PE_LAT     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_seq_ctrl_if.master bus
);

  localparam int                  c_KW    = ADDRSIZE - 1;
  localparam logic [ADDRSIZE-1:0] c_LAST  = ADDRSIZE'(NUMSAMPLES - 1);
  localparam logic [c_KW-1:0]     c_KLAST = c_KW'(NUMSAMPLES / 2 - 1);
  localparam logic [ADDRSIZE-1:0] c_SLAST = ADDRSIZE'(NUMSTAGES - 1);
  localparam logic [2:0]          c_FLAST = 3'((PE_LAT > 0) ? PE_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_RAMRDY = 3'd1,
    S_STAGE  = 3'd2,
    S_FLUSH  = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t              r_state, w_state_nx;
  logic [ADDRSIZE-1:0] r_lcnt, w_lcnt_nx;
  logic [ADDRSIZE-1:0] r_stage, w_stage_nx;
  logic [ADDRSIZE-1:0] r_ucnt, w_ucnt_nx;
  logic [c_KW-1:0]     r_k, w_k_nx;
  logic [2:0]          r_fcnt, w_fcnt_nx;
  logic                r_conj, w_conj_nx;
  logic                w_done_nx, w_stage_end;
  logic                w_ld_acc, w_ul_acc;

  logic                r_ld_ready, r_rd_en, r_busy, r_ul_valid, r_ul_last, r_done;
  logic [ADDRSIZE-1:0] r_rd_a, r_rd_b, r_ul_addr;
  logic [c_KW-1:0]     r_tw;

  logic                w_rd_nx, w_ul_nx;
  logic [c_KW-1:0]     w_mask, w_j, w_tw;
  logic [ADDRSIZE-1:0] w_h, w_rd_a, w_rd_b, w_ul_rev;

  assign w_ld_acc = bus.ld_valid & r_ld_ready;
  assign w_ul_acc = r_ul_valid & bus.ul_ready;

  // Next-state and counter logic of the load / compute / unload sequence
  always_comb begin
    w_state_nx  = r_state;
    w_lcnt_nx   = r_lcnt;
    w_stage_nx  = r_stage;
    w_k_nx      = r_k;
    w_fcnt_nx   = r_fcnt;
    w_ucnt_nx   = r_ucnt;
    w_conj_nx   = r_conj;
    w_done_nx   = 1'b0;
    w_stage_end = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_ld_acc) begin
          w_lcnt_nx = r_lcnt + ADDRSIZE'(1);
          if (r_lcnt == c_LAST) w_state_nx = S_RAMRDY;
        end
      end
      S_RAMRDY: begin
        if (bus.start) begin
          w_state_nx = S_STAGE;
          w_stage_nx = '0;
          w_k_nx     = '0;
          w_conj_nx  = bus.inverse;
        end
      end
      S_STAGE: begin
        if (r_k == c_KLAST) begin
          if (PE_LAT > 0) begin
            w_state_nx = S_FLUSH;
            w_fcnt_nx  = '0;
          end else begin
            w_stage_end = 1'b1;
          end
        end else begin
          w_k_nx = r_k + c_KW'(1);
        end
      end
      S_FLUSH: begin
        if (r_fcnt == c_FLAST) w_stage_end = 1'b1;
        else                   w_fcnt_nx   = r_fcnt + 3'd1;
      end
      S_UNLOAD: begin
        if (w_ul_acc) begin
          w_ucnt_nx = r_ucnt + ADDRSIZE'(1);
          if (r_ucnt == c_LAST) begin
            w_state_nx = S_LOAD;
            w_done_nx  = 1'b1;
          end
        end
      end
      default: w_state_nx = S_LOAD;
    endcase
    // Writes of the finished stage have drained: advance or start unloading
    if (w_stage_end) begin
      if (r_stage == c_SLAST) begin
        w_state_nx = S_UNLOAD;
        w_ucnt_nx  = '0;
      end else begin
        w_state_nx = S_STAGE;
        w_stage_nx = r_stage + ADDRSIZE'(1);
        w_k_nx     = '0;
      end
    end
  end

  // Butterfly addressing for the next (stage, k): h = N>>(s+1), mask = h-1,
  // upper leg = ((k & ~mask) << 1) | (k & mask), lower leg = upper + h
  always_comb begin
    w_mask   = c_KLAST >> w_stage_nx;
    w_j      = w_k_nx & w_mask;
    w_h      = {1'b0, w_mask} + ADDRSIZE'(1);
    w_rd_a   = {w_k_nx & ~w_mask, 1'b0} | {1'b0, w_j};
    w_rd_b   = w_rd_a | w_h;
    w_tw     = w_j << w_stage_nx;
    w_rd_nx  = (w_state_nx == S_STAGE);
    w_ul_nx  = (w_state_nx == S_UNLOAD);
    w_ul_rev = '0;
    for (int i = 0; i < ADDRSIZE; i++) begin
      w_ul_rev[i] = w_ucnt_nx[ADDRSIZE-1-i];
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_lcnt  <= '0;
      r_stage <= '0;
      r_ucnt  <= '0;
      r_k     <= '0;
      r_fcnt  <= '0;
      r_conj  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_lcnt  <= w_lcnt_nx;
      r_stage <= w_stage_nx;
      r_ucnt  <= w_ucnt_nx;
      r_k     <= w_k_nx;
      r_fcnt  <= w_fcnt_nx;
      r_conj  <= w_conj_nx;
    end
  end

  // Output registers, computed from the next state so they align with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ld_ready <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_a     <= '0;
      r_rd_b     <= '0;
      r_tw       <= '0;
      r_busy     <= 1'b0;
      r_ul_valid <= 1'b0;
      r_ul_addr  <= '0;
      r_ul_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ld_ready <= (w_state_nx == S_LOAD);
      r_rd_en    <= w_rd_nx;
      r_rd_a     <= w_rd_nx ? w_rd_a : '0;
      r_rd_b     <= w_rd_nx ? w_rd_b : '0;
      r_tw       <= w_rd_nx ? w_tw : '0;
      r_busy     <= w_rd_nx | (w_state_nx == S_FLUSH);
      r_ul_valid <= w_ul_nx;
      r_ul_addr  <= w_ul_nx ? w_ul_rev : '0;
      r_ul_last  <= w_ul_nx & (w_ucnt_nx == c_LAST);
      r_done     <= w_done_nx;
    end
  end

  // Write-back strobe/addresses follow the read issue by PE_LAT cycles
  if (PE_LAT == 0) begin : g_wb_direct
    assign bus.wr_en     = r_rd_en;
    assign bus.wr_addr_a = r_rd_a;
    assign bus.wr_addr_b = r_rd_b;
  end else begin : g_wb_pipe
    logic                r_pen [PE_LAT];
    logic [ADDRSIZE-1:0] r_pa  [PE_LAT];
    logic [ADDRSIZE-1:0] r_pb  [PE_LAT];

    // Delay line; reset discards any write-backs still in flight
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < PE_LAT; i++) begin
          r_pen[i] <= 1'b0;
          r_pa[i]  <= '0;
          r_pb[i]  <= '0;
        end
      end else begin
        r_pen[0] <= r_rd_en;
        r_pa[0]  <= r_rd_a;
        r_pb[0]  <= r_rd_b;
        for (int i = 1; i < PE_LAT; i++) begin
          r_pen[i] <= r_pen[i-1];
          r_pa[i]  <= r_pa[i-1];
          r_pb[i]  <= r_pb[i-1];
        end
      end
    end

    assign bus.wr_en     = r_pen[PE_LAT-1];
    assign bus.wr_addr_a = r_pa[PE_LAT-1];
    assign bus.wr_addr_b = r_pb[PE_LAT-1];
  end

  assign bus.ld_ready  = r_ld_ready;
  assign bus.ld_we     = w_ld_acc;
  assign bus.ld_addr   = r_lcnt;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr_a = r_rd_a;
  assign bus.rd_addr_b = r_rd_b;
  assign bus.tw_idx    = r_tw;
  assign bus.tw_conj   = r_conj;
  assign bus.stage_num = r_stage;
  assign bus.busy      = r_busy;
  assign bus.ul_valid  = r_ul_valid;
  assign bus.ul_addr   = r_ul_addr;
  assign bus.ul_last   = r_ul_last;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_fft_seq_ctrl
//  Brief   : Directed bench for fft_seq_ctrl: N=32/PE_LAT=2 and
//            N=64/PE_LAT=0 instances, address table plus multi-cycle
//            sequences for load, compute, unload and reset.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_fft_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_seq_ctrl_if #(.ADDRSIZE(5)) bus ();
  fft_seq_ctrl_if #(.ADDRSIZE(6)) bus64 ();

  fft_seq_ctrl #(.NUMSAMPLES(32), .ADDRSIZE(5), .NUMSTAGES(5), .PE_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fft_seq_ctrl #(.NUMSAMPLES(64), .ADDRSIZE(6), .NUMSTAGES(6), .PE_LAT(0)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64)
  );

  typedef struct {
    int s;
    int k;
    int a;
    int b;
    int tw;
  } addr_vec_t;

  addr_vec_t vt [8];
  int        ul_tab [5];
  int        ul_seq [32];
  int        cap_a [80];
  int        cap_b [80];
  int        cap_tw [80];
  int        rc;
  int        n_vec = 0;
  int        n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bitrev(input int x, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (x[i]) r |= (1 << (w - 1 - i));
    return r;
  endfunction

  function automatic logic any_out32();
    return bus.ld_ready | bus.ld_we | (|bus.ld_addr) | bus.rd_en | (|bus.rd_addr_a) |
           (|bus.rd_addr_b) | (|bus.tw_idx) | bus.tw_conj | bus.wr_en | (|bus.wr_addr_a) |
           (|bus.wr_addr_b) | (|bus.stage_num) | bus.busy | bus.ul_valid | (|bus.ul_addr) |
           bus.ul_last | bus.done;
  endfunction

  // Load 32 samples, every cycle or on alternate cycles; ends in RAMRDY
  task automatic load_all(input bit alt);
    int acc = 0;
    int err = 0;
    for (int c = 0; c < 200 && acc < 32; c++) begin
      bus.ld_valid = alt ? (c % 2 == 0) : 1'b1;
      #1;
      if (bus.ld_ready !== 1'b1 || bus.busy !== 1'b0) err++;
      if (bus.ld_we !== bus.ld_valid) err++;
      if (bus.ld_we === 1'b1) begin
        if (bus.ld_addr !== 5'(acc)) err++;
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.ld_valid = 1'b0;
    chk("load_count", acc, 32);
    chk("load_seq", err, 0);
    chk("load_ready_drop", bus.ld_ready, 1'b0);
    chk("ramrdy_idle", bus.rd_en | bus.busy, 1'b0);
  endtask

  // Observe one complete compute run from its first busy cycle
  task automatic run_compute(input bit inv, input bit toggle);
    int   i = 0;
    int   err_rd = 0, err_wr = 0, err_cj = 0, err_st = 0, wc = 0;
    logic            hen [100];
    logic [4:0]      ha [100];
    logic [4:0]      hb [100];
    rc = 0;
    while (bus.busy === 1'b1 && i < 100) begin
      if (toggle) bus.inverse = i[0];
      if (bus.rd_en !== ((i % 18) < 16)) err_rd++;
      if (bus.tw_conj !== inv) err_cj++;
      hen[i] = bus.rd_en;
      ha[i]  = bus.rd_addr_a;
      hb[i]  = bus.rd_addr_b;
      if (bus.rd_en === 1'b1) begin
        if (bus.stage_num !== 5'(rc / 16)) err_st++;
        if (rc < 80) begin
          cap_a[rc]  = int'(bus.rd_addr_a);
          cap_b[rc]  = int'(bus.rd_addr_b);
          cap_tw[rc] = int'(bus.tw_idx);
        end
        rc++;
      end
      if (i >= 2) begin
        if (bus.wr_en !== hen[i-2]) err_wr++;
        else if (hen[i-2] && (bus.wr_addr_a !== ha[i-2] || bus.wr_addr_b !== hb[i-2])) err_wr++;
      end else if (bus.wr_en !== 1'b0) begin
        err_wr++;
      end
      if (bus.wr_en === 1'b1) wc++;
      i++;
      tick();
    end
    chk("busy_cycles", i, 90);
    chk("rd_count", rc, 80);
    chk("rd_flush_pattern", err_rd, 0);
    chk("wr_delay", err_wr, 0);
    chk("wr_count", wc, 80);
    chk("tw_conj_run", err_cj, 0);
    chk("stage_num_run", err_st, 0);
    chk("post_run_wr_en", bus.wr_en, 1'b0);
    chk("post_run_ul_valid", bus.ul_valid, 1'b1);
  endtask

  // Unload 32 addresses, optionally with ul_ready toggling
  task automatic unload(input bit toggle);
    int u = 0, err = 0, c = 0;
    bit fin = 1'b0;
    while (!fin && c < 300) begin
      bus.ul_ready = toggle ? c[0] : 1'b1;
      if (bus.ul_valid !== 1'b1 || bus.ul_addr !== 5'(bitrev(u, 5)) ||
          bus.ul_last !== (u == 31) || bus.done !== 1'b0 || bus.busy !== 1'b0) err++;
      if (bus.ul_ready) begin
        ul_seq[u] = int'(bus.ul_addr);
        u++;
        if (u == 32) fin = 1'b1;
      end
      c++;
      tick();
    end
    bus.ul_ready = 1'b0;
    chk("ul_count", u, 32);
    chk("ul_addr_seq", err, 0);
    chk("done_pulse", bus.done, 1'b1);
    chk("ld_ready_after_done", bus.ld_ready, 1'b1);
    chk("ul_valid_after_done", bus.ul_valid, 1'b0);
    tick();
    chk("done_clear", bus.done, 1'b0);
  endtask

  initial begin
    int c, acc, err, u, i;
    vt[0] = '{0,  0,  0, 16,  0};
    vt[1] = '{0, 15, 15, 31, 15};
    vt[2] = '{1,  8, 16, 24,  0};
    vt[3] = '{4,  3,  6,  7,  0};
    vt[4] = '{2,  5,  9, 13,  4};
    vt[5] = '{3,  7, 13, 15,  8};
    vt[6] = '{1,  3,  3, 11,  6};
    vt[7] = '{3,  6, 12, 14,  0};
    ul_tab = '{0, 16, 8, 24, 4};

    rst_n = 1'b0;
    bus.ld_valid = 1'b0; bus.start = 1'b0; bus.inverse = 1'b0; bus.ul_ready = 1'b0;
    bus64.ld_valid = 1'b0; bus64.start = 1'b0; bus64.inverse = 1'b0; bus64.ul_ready = 1'b0;

    // reset state
    repeat (3) tick();
    chk("reset_outputs", any_out32(), 1'b0);
    chk("reset_outputs64", bus64.ld_ready | bus64.busy | bus64.rd_en | bus64.ul_valid | bus64.done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("ld_ready_release", bus.ld_ready, 1'b1);

    // alternate-cycle load with start held, forward run, toggling unload
    bus.start = 1'b1;
    load_all(1'b1);
    tick();
    chk("first_rd_after_start", bus.rd_en, 1'b1);
    run_compute(1'b0, 1'b0);
    bus.start = 1'b0;
    for (int v = 0; v < 8; v++) begin
      i = vt[v].s * 16 + vt[v].k;
      chk("tab_rd_addr_a", cap_a[i], vt[v].a);
      chk("tab_rd_addr_b", cap_b[i], vt[v].b);
      chk("tab_tw_idx", cap_tw[i], vt[v].tw);
    end
    unload(1'b1);
    for (int v = 0; v < 5; v++) chk("tab_ul_addr", ul_seq[v], ul_tab[v]);

    // inverse run, inverse toggled during compute
    bus.inverse = 1'b1;
    load_all(1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_compute(1'b1, 1'b1);
    bus.inverse = 1'b0;
    unload(1'b0);
    chk("tw_conj_hold", bus.tw_conj, 1'b1);

    // reset in the middle of stage 2
    load_all(1'b0);
    bus.start = 1'b1;
    bus.inverse = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 0;
    while (!(bus.stage_num === 5'd2 && bus.rd_en === 1'b1) && c < 200) begin
      c++;
      tick();
    end
    chk("reach_stage2", bus.stage_num, 2);
    rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("mid_reset_outputs", any_out32(), 1'b0);
    end
    rst_n = 1'b1;
    tick();
    chk("ld_ready_after_reset", bus.ld_ready, 1'b1);
    err = 0;
    for (int r = 0; r < 5; r++) begin
      if (bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 || bus.busy !== 1'b0) err++;
      tick();
    end
    chk("no_wr_after_reset", err, 0);

    // N=64, PE_LAT=0 instance
    bus64.start = 1'b1;
    acc = 0;
    for (int k = 0; k < 100 && acc < 64; k++) begin
      bus64.ld_valid = 1'b1;
      #1;
      if (bus64.ld_we === 1'b1) acc++;
      @(posedge clk);
      #1;
    end
    bus64.ld_valid = 1'b0;
    chk("load64_count", acc, 64);
    c = 0;
    while (bus64.busy !== 1'b1 && c < 5) begin
      c++;
      tick();
    end
    chk("first_rd64_a", bus64.rd_addr_a, 0);
    chk("first_rd64_b", bus64.rd_addr_b, 32);
    i = 0;
    err = 0;
    while (bus64.busy === 1'b1 && i < 300) begin
      if (bus64.rd_en !== 1'b1 || bus64.wr_en !== bus64.rd_en || bus64.tw_conj !== 1'b0 ||
          bus64.wr_addr_a !== bus64.rd_addr_a || bus64.wr_addr_b !== bus64.rd_addr_b) err++;
      i++;
      tick();
    end
    bus64.start = 1'b0;
    chk("busy64_cycles", i, 192);
    chk("no_flush64", err, 0);
    u = 0;
    err = 0;
    for (int k = 0; k < 100 && u < 64; k++) begin
      bus64.ul_ready = 1'b1;
      if (bus64.ul_valid !== 1'b1 || bus64.ul_addr !== 6'(bitrev(u, 6)) ||
          bus64.ul_last !== (u == 63)) err++;
      u++;
      tick();
    end
    bus64.ul_ready = 1'b0;
    chk("ul64_addr_seq", err, 0);
    chk("done64_pulse", bus64.done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
